mesh_path_scheduler: RTL and testbench
======================================

Name: mesh_path_scheduler

Overview:
- Sequencing core for the 2x2 mesh (routers 0-1 bottom, 2-3 top).
- Takes per-processor transfer requests (destination + burst length) and the 28-bit path-free vector from the mesh.
- Picks a free route round-robin and tracks up to 4 concurrent bursts with per-source beat counters.
- Emits grant/release events for the router configuration logic and per-processor response levels.

Parameters:
- LEN_W, 8, burst length width.
- HOLDOFF, 1, cycles grant search is suppressed after any grant or release, so path-free bits can settle.
- TIMEOUT_CYC, 64, starvation limit; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  transfer request per processor, bit k = processor k.
- req_dest  in  8  destination, 2 bits per processor; [2k+1:2k] belongs to processor k.
- req_len  in  4*LEN_W  burst length per processor; [LEN_W*k +: LEN_W] belongs to processor k.
- path_free  in  28  processor 0 uses [27:21], processor 1 [20:14], processor 2 [13:7], processor 3 [6:0]. Per-source bit i:
  - bit 0: self.
  - bits 1 and 2: horizontal neighbour, short and long route.
  - bits 3 and 4: vertical neighbour, short and long route.
  - bits 5 and 6: diagonal, via vertical and via flat.
- grant_valid  out  1  one-cycle pulse, new route granted.
- grant_src  out  2  granted source.
- grant_dst  out  2  granted destination.
- grant_path  out  3  chosen path index, 0..6.
- release_valid  out  1  one-cycle pulse, route of release_src is freed.
- release_src  out  2  source whose burst finished.
- response  out  4  level, high for exactly len cycles while source k may drive data.
- active  out  4  source k owns a route.
- done  out  4  one-cycle completion pulse per source.
- timeout  out  4  starvation pulse per source; tied 0 without the optional feature.

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0, rr_ptr to 0, holdoff counter to 0, all counters cleared.
- Reset mid-burst aborts the burst silently: no done pulse, no release pulse.
- Relation: rel = src XOR dest.
  - rel 0 uses candidate bit 0.
  - rel 1 uses bits 1 then 2.
  - rel 2 uses bits 3 then 4.
  - rel 3 uses bits 5 then 6.
  - The lower index is preferred when both candidates are free.
- Eligible source: req=1, active=0, len≠0, at least one candidate bit =1.
- Arbitration (cycle t): runs only when the holdoff counter is 0 and release is not firing in cycle t.
  - Search starts at rr_ptr and wraps 3→0. The first eligible source wins. At most one grant per cycle.
- At edge t+1, all of the following register together:
  - grant_valid=1, with grant_src, grant_dst and grant_path.
  - active[k]=1 and response[k]=1.
  - Beat counter loaded with len, which is sampled at cycle t.
  - rr_ptr = (k+1) mod 4.
  - Holdoff counter = HOLDOFF.
- Counter handling:
  - The counter decrements each cycle while response[k]=1.
  - On the edge where the counter goes 1→0: response[k]=0, active[k]=0, done[k]=1, release_valid=1, release_src=k, holdoff counter reloaded.
  - Net result: response is high on cycles t+1..t+len; done and release come at t+len+1.
- Simultaneous completions: if two counters reach 0 on the same edge, the lower index is released first. The other source stays active with response=0 and is released on the next cycle.
- len=0 with req=1 and not active: done[k] pulses the next cycle. No grant, no path check.
- req is not latched. Dropping it before the grant withdraws the request. Changes to req, req_dest or req_len while active are ignored.
- Re-request: req held high after done makes the source eligible again once holdoff expires.
- States per source: IDLE → ACTIVE (at grant) → DRAIN (only when the release port is busy) → IDLE.
- Global holdoff states: SEARCH ↔ HOLD.

Optional Feature:
- Macro PATH_SCHED_TIMEOUT_EN.
- Defined:
  - A per-source wait counter increments while req=1 and active=0, and clears on grant or when req=0.
  - At TIMEOUT_CYC the source gets timeout[k]=1 for one cycle.
  - The source is then masked from arbitration until req deasserts.
- Undefined: timeout=0 and no wait counters.

Test Plan:
- P0 req dest=1, len=3, path_free[22]=1: grant_valid at cycle 1 with src=0, dst=1, path=1. response[0] high cycles 1-3. done[0] and release_valid at cycle 4.
- P0 dest=1 with [22]=0 and [23]=1: grant_path=2. With both 0: no grant while req is held.
- P1, P2, P3 request together, rr_ptr=0, all paths free: grants in order 1, 2, 3, each separated by at least 1 holdoff cycle. rr_ptr ends at 0.
- P2 req len=0: done[2] pulses the next cycle. No grant_valid and no response.
- Two bursts finishing on the same edge (src 0 and 3): release_src=0 then 3 on consecutive cycles. done[0] and done[3] each pulse once.
- Reset asserted mid-burst (len=10, cycle 4): all outputs 0 asynchronously, no done pulse. Under PATH_SCHED_TIMEOUT_EN with TIMEOUT_CYC=64, a blocked P3 gets timeout[3] at wait cycle 64.

Source files
------------

// File: rtl/mesh_path_scheduler.sv
// mesh_path_scheduler
// Sequencing core for the 2x2 mesh (routers 0-1 bottom, 2-3 top).
// Accepts per-processor transfer requests, picks a free route round-robin,
// tracks up to four concurrent bursts with per-source beat counters and
// emits grant/release events for the router configuration logic.
//
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   req[3:0]           transfer request, bit k = processor k
//   req_dest[7:0]      destination, [2k+1:2k] for processor k
//   req_len            burst length, [LEN_W*k +: LEN_W] for processor k
//   path_free[27:0]    7 candidate bits per source, processor 0 at [27:21]
//   grant_*            one-cycle grant event with source, destination, path
//   release_*          one-cycle release event with freed source
//   response[3:0]      high for exactly len cycles while source k may drive data
//   active[3:0]        source k owns a route
//   done[3:0]          one-cycle completion pulse per source
//   timeout[3:0]       starvation pulse per source
//
// Optional feature macro: PATH_SCHED_TIMEOUT_EN
//   defined   - per-source wait counters raise timeout[k] after TIMEOUT_CYC
//               waiting cycles and mask the source until req[k] drops
//   undefined - timeout is tied to 0

module mesh_path_scheduler #(
    parameter int LEN_W       = 8,
    parameter int HOLDOFF     = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [7:0]         req_dest,
    input  logic [4*LEN_W-1:0] req_len,
    input  logic [27:0]        path_free,
    output logic               grant_valid,
    output logic [1:0]         grant_src,
    output logic [1:0]         grant_dst,
    output logic [2:0]         grant_path,
    output logic               release_valid,
    output logic [1:0]         release_src,
    output logic [3:0]         response,
    output logic [3:0]         active,
    output logic [3:0]         done,
    output logic [3:0]         timeout
);

    localparam int HO_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

    // Parameter sanity checks at elaboration
    if (LEN_W < 1) begin : g_bad_len_w
        $error("LEN_W must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be positive");
    end

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_ACTIVE,
        SRC_DRAIN
    } src_state_t;

    src_state_t       src_state [4];
    logic [LEN_W-1:0] beat_cnt  [4];
    logic [1:0]       rr_ptr;
    logic [HO_W-1:0]  hold_cnt;

    logic [3:0] path_ok;
    logic [2:0] path_sel [4];
    logic [6:0] pf_bits;
    logic [1:0] rel;
    logic [3:0] eligible;
    logic [3:0] zero_len;
    logic [3:0] rel_pending;
    logic [3:0] arb_mask;
    logic       rel_fire;
    logic [1:0] rel_idx;
    logic       gnt_fire;
    logic [1:0] gnt_idx;
    logic [1:0] scan_idx;

    // Route choice per source: rel = src ^ dest selects a candidate pair,
    // the lower index wins when both candidates are free.
    always_comb begin
        path_ok = '0;
        pf_bits = '0;
        rel     = '0;
        for (int k = 0; k < 4; k++) begin
            path_sel[k] = 3'd0;
        end
        for (int k = 0; k < 4; k++) begin
            pf_bits = path_free[(3-k)*7 +: 7];
            rel     = 2'(k) ^ req_dest[2*k +: 2];
            case (rel)
                2'd0: if (pf_bits[0]) begin path_ok[k] = 1'b1; path_sel[k] = 3'd0; end
                2'd1: if (pf_bits[1]) begin path_ok[k] = 1'b1; path_sel[k] = 3'd1; end
                      else if (pf_bits[2]) begin path_ok[k] = 1'b1; path_sel[k] = 3'd2; end
                2'd2: if (pf_bits[3]) begin path_ok[k] = 1'b1; path_sel[k] = 3'd3; end
                      else if (pf_bits[4]) begin path_ok[k] = 1'b1; path_sel[k] = 3'd4; end
                default: if (pf_bits[5]) begin path_ok[k] = 1'b1; path_sel[k] = 3'd5; end
                      else if (pf_bits[6]) begin path_ok[k] = 1'b1; path_sel[k] = 3'd6; end
            endcase
        end
    end

    // Eligibility, zero-length completions and release candidates.
    // A source finishing this edge and a source already parked in DRAIN
    // both compete for the single release port; lowest index goes first.
    always_comb begin
        eligible    = '0;
        zero_len    = '0;
        rel_pending = '0;
        rel_fire    = 1'b0;
        rel_idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            eligible[k]    = req[k] && (src_state[k] == SRC_IDLE) &&
                             (|req_len[LEN_W*k +: LEN_W]) && path_ok[k] && !arb_mask[k];
            zero_len[k]    = req[k] && (src_state[k] == SRC_IDLE) &&
                             !(|req_len[LEN_W*k +: LEN_W]);
            rel_pending[k] = ((src_state[k] == SRC_ACTIVE) && (beat_cnt[k] == LEN_W'(1))) ||
                             (src_state[k] == SRC_DRAIN);
        end
        for (int k = 3; k >= 0; k--) begin
            if (rel_pending[k]) begin
                rel_fire = 1'b1;
                rel_idx  = 2'(k);
            end
        end
    end

    // Round-robin search from rr_ptr; suppressed during holdoff and while
    // a release is going out so path-free bits can settle.
    always_comb begin
        gnt_fire = 1'b0;
        gnt_idx  = 2'd0;
        scan_idx = 2'd0;
        if ((hold_cnt == '0) && !rel_fire) begin
            for (int i = 0; i < 4; i++) begin
                scan_idx = rr_ptr + 2'(i);
                if (!gnt_fire && eligible[scan_idx]) begin
                    gnt_fire = 1'b1;
                    gnt_idx  = scan_idx;
                end
            end
        end
    end

    // Per-source burst FSMs, release port, grant port and holdoff counter.
    // Release and grant are mutually exclusive in a cycle, so the release
    // branch takes precedence without starving anything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_valid   <= 1'b0;
            grant_src     <= 2'd0;
            grant_dst     <= 2'd0;
            grant_path    <= 3'd0;
            release_valid <= 1'b0;
            release_src   <= 2'd0;
            response      <= '0;
            active        <= '0;
            done          <= '0;
            rr_ptr        <= 2'd0;
            hold_cnt      <= '0;
            for (int k = 0; k < 4; k++) begin
                src_state[k] <= SRC_IDLE;
                beat_cnt[k]  <= '0;
            end
        end else begin
            grant_valid   <= 1'b0;
            release_valid <= 1'b0;
            done          <= zero_len;
            for (int k = 0; k < 4; k++) begin
                if (src_state[k] == SRC_ACTIVE) begin
                    beat_cnt[k] <= beat_cnt[k] - LEN_W'(1);
                    if (beat_cnt[k] == LEN_W'(1)) begin
                        src_state[k] <= SRC_DRAIN;
                        response[k]  <= 1'b0;
                    end
                end
            end
            if (rel_fire) begin
                release_valid      <= 1'b1;
                release_src        <= rel_idx;
                done[rel_idx]      <= 1'b1;
                src_state[rel_idx] <= SRC_IDLE;
                active[rel_idx]    <= 1'b0;
                response[rel_idx]  <= 1'b0;
                hold_cnt           <= HO_W'(HOLDOFF);
            end else if (gnt_fire) begin
                grant_valid        <= 1'b1;
                grant_src          <= gnt_idx;
                grant_dst          <= req_dest[2*gnt_idx +: 2];
                grant_path         <= path_sel[gnt_idx];
                src_state[gnt_idx] <= SRC_ACTIVE;
                beat_cnt[gnt_idx]  <= req_len[LEN_W*gnt_idx +: LEN_W];
                active[gnt_idx]    <= 1'b1;
                response[gnt_idx]  <= 1'b1;
                rr_ptr             <= gnt_idx + 2'd1;
                hold_cnt           <= HO_W'(HOLDOFF);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HO_W'(1);
            end
        end
    end

`ifdef PATH_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] wait_cnt [4];
    logic [3:0]      starve_mask;

    assign arb_mask = starve_mask;

    // Starvation watch: count idle waiting cycles, pulse timeout once the
    // limit is reached and keep the source out of arbitration until its
    // request drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout     <= '0;
            starve_mask <= '0;
            for (int k = 0; k < 4; k++) begin
                wait_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                timeout[k] <= 1'b0;
                if (!req[k]) begin
                    wait_cnt[k]    <= '0;
                    starve_mask[k] <= 1'b0;
                end else if (gnt_fire && (gnt_idx == 2'(k))) begin
                    wait_cnt[k] <= '0;
                end else if ((src_state[k] == SRC_IDLE) && !starve_mask[k]) begin
                    if (wait_cnt[k] == TO_W'(TIMEOUT_CYC - 1)) begin
                        timeout[k]     <= 1'b1;
                        starve_mask[k] <= 1'b1;
                        wait_cnt[k]    <= '0;
                    end else begin
                        wait_cnt[k] <= wait_cnt[k] + TO_W'(1);
                    end
                end
            end
        end
    end
`else
    assign arb_mask = '0;
    assign timeout  = '0;
`endif

endmodule

// File: tb/tb_mesh_path_scheduler.sv
// Testbench for mesh_path_scheduler: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model that
// tracks bursts as "remaining beats" and releases as "ended, not yet freed".

module tb_mesh_path_scheduler;

    localparam int LEN_W   = 8;
    localparam int HOLDOFF = 1;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         req = '0;
    logic [7:0]         req_dest = '0;
    logic [4*LEN_W-1:0] req_len = '0;
    logic [27:0]        path_free = '0;
    logic               grant_valid;
    logic [1:0]         grant_src;
    logic [1:0]         grant_dst;
    logic [2:0]         grant_path;
    logic               release_valid;
    logic [1:0]         release_src;
    logic [3:0]         response;
    logic [3:0]         active;
    logic [3:0]         done;
    logic [3:0]         timeout;

    mesh_path_scheduler #(
        .LEN_W(LEN_W),
        .HOLDOFF(HOLDOFF),
        .TIMEOUT_CYC(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .req_dest(req_dest),
        .req_len(req_len),
        .path_free(path_free),
        .grant_valid(grant_valid),
        .grant_src(grant_src),
        .grant_dst(grant_dst),
        .grant_path(grant_path),
        .release_valid(release_valid),
        .release_src(release_src),
        .response(response),
        .active(active),
        .done(done),
        .timeout(timeout)
    );

    // Free-running clock
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    bit m_own   [4];
    bit m_resp  [4];
    bit m_ended [4];
    int m_left  [4];
    int m_rr;
    int m_hold;

    // Expected outputs after the next edge
    bit         e_gv, e_rv;
    int         e_gs, e_gd, e_gp, e_rs;
    logic [3:0] e_resp, e_act, e_done;

    int grant_log[$];
    int grant_cyc[$];
    int release_log[$];
    int release_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // First free candidate for src->dst, or -1; pair of candidates is
    // 2*rel-1 and 2*rel for rel = src ^ dst, single bit 0 for self.
    function automatic int route(input int src, input int dst, input logic [27:0] pf);
        int rel = src ^ dst;
        int base = (3 - src) * 7;
        if (rel == 0) return pf[base] ? 0 : -1;
        for (int c = 2 * rel - 1; c <= 2 * rel; c++) begin
            if (pf[base + c]) return c;
        end
        return -1;
    endfunction

    function automatic int len_of(input int k);
        return int'(req_len[LEN_W*k +: LEN_W]);
    endfunction

    function automatic int dest_of(input int k);
        return int'(req_dest[2*k +: 2]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_own[k] = 0; m_resp[k] = 0; m_ended[k] = 0; m_left[k] = 0;
        end
        m_rr = 0; m_hold = 0;
        e_gv = 0; e_rv = 0; e_gs = 0; e_gd = 0; e_gp = 0; e_rs = 0;
        e_resp = '0; e_act = '0; e_done = '0;
    endtask

    // Advance the model by one clock given the inputs currently applied
    task automatic model_step();
        int rel_src = -1;
        int g = -1;
        e_gv = 0; e_rv = 0; e_done = '0;
        for (int k = 3; k >= 0; k--) begin
            if ((m_resp[k] && m_left[k] == 1) || m_ended[k]) rel_src = k;
        end
        for (int k = 0; k < 4; k++) begin
            if (req[k] && !m_own[k] && len_of(k) == 0) e_done[k] = 1'b1;
        end
        if (m_hold == 0 && rel_src < 0) begin
            for (int i = 0; i < 4; i++) begin
                int k = (m_rr + i) % 4;
                if (g < 0 && req[k] && !m_own[k] && len_of(k) != 0 &&
                    route(k, dest_of(k), path_free) >= 0) g = k;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (m_resp[k]) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_resp[k]  = 0;
                    m_ended[k] = 1;
                end
            end
        end
        if (rel_src >= 0) begin
            e_rv = 1; e_rs = rel_src;
            e_done[rel_src] = 1'b1;
            m_own[rel_src] = 0; m_ended[rel_src] = 0;
            m_hold = HOLDOFF;
        end else if (g >= 0) begin
            e_gv = 1; e_gs = g; e_gd = dest_of(g); e_gp = route(g, dest_of(g), path_free);
            m_own[g] = 1; m_resp[g] = 1; m_left[g] = len_of(g);
            m_rr = (g + 1) % 4;
            m_hold = HOLDOFF;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        for (int k = 0; k < 4; k++) begin
            e_resp[k] = m_resp[k];
            e_act[k]  = m_own[k];
        end
    endtask

    task automatic check_output();
        check("grant_valid", 32'(grant_valid), 32'(e_gv));
        if (e_gv) begin
            check("grant_src", 32'(grant_src), 32'(e_gs));
            check("grant_dst", 32'(grant_dst), 32'(e_gd));
            check("grant_path", 32'(grant_path), 32'(e_gp));
        end
        check("release_valid", 32'(release_valid), 32'(e_rv));
        if (e_rv) check("release_src", 32'(release_src), 32'(e_rs));
        check("response", 32'(response), 32'(e_resp));
        check("active", 32'(active), 32'(e_act));
        check("done", 32'(done), 32'(e_done));
        check("timeout", 32'(timeout), 32'd0);
        if (grant_valid === 1'b1) begin
            grant_log.push_back(int'(grant_src));
            grant_cyc.push_back(cyc);
        end
        if (release_valid === 1'b1) begin
            release_log.push_back(int'(release_src));
            release_cyc.push_back(cyc);
        end
    endtask

    // One clock: predict, clock the DUT, compare just after the edge
    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        check_output();
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [7:0] d,
                                  input int l0, input int l1, input int l2, input int l3,
                                  input logic [27:0] pf);
        req       = r;
        req_dest  = d;
        req_len   = {LEN_W'(l3), LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
        path_free = pf;
    endtask

    task automatic do_reset();
        apply_stimulus(4'b0, 8'b0, 0, 0, 0, 0, 28'b0);
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        model_reset();
        check_output();
        check("reset_grant_src", 32'(grant_src), 32'd0);
        check("reset_grant_path", 32'(grant_path), 32'd0);
        check("reset_release_src", 32'(release_src), 32'd0);
        reset = 1'b0;
        cyc = 0;
        grant_log.delete(); grant_cyc.delete();
        release_log.delete(); release_cyc.delete();
    endtask

    initial begin
        int n;
        logic [27:0] pf;

        // Single burst P0 -> 1 over the short horizontal route
        do_reset();
        pf = '0; pf[22] = 1'b1;
        apply_stimulus(4'b0001, 8'b0000_0001, 3, 0, 0, 0, pf);
        step();
        check("s1_grant", 32'({grant_valid, grant_src, grant_dst, grant_path}), 32'({1'b1, 2'd0, 2'd1, 3'd1}));
        req = 4'b0;
        step();
        step();
        check("s1_resp_c3", 32'(response[0]), 32'd1);
        step();
        check("s1_done_c4", 32'({done[0], release_valid, response[0]}), 32'({1'b1, 1'b1, 1'b0}));

        // Long route fallback, then no route at all
        do_reset();
        pf = '0; pf[23] = 1'b1;
        apply_stimulus(4'b0001, 8'b0000_0001, 3, 0, 0, 0, pf);
        step();
        check("s2_long_path", 32'(grant_path), 32'd2);
        req = 4'b0;
        repeat (6) step();
        apply_stimulus(4'b0001, 8'b0000_0001, 3, 0, 0, 0, 28'b0);
        n = grant_log.size();
        repeat (8) step();
        check("s2_no_grant", 32'(grant_log.size()), 32'(n));

        // Three simultaneous requesters granted round-robin from 0
        do_reset();
        apply_stimulus(4'b1110, 8'b0, 1, 1, 1, 1, '1);
        repeat (12) step();
        req = 4'b0;
        repeat (4) step();
        check("s3_count", 32'(grant_log.size() >= 3), 32'd1);
        if (grant_log.size() >= 3) begin
            check("s3_first", 32'(grant_log[0]), 32'd1);
            check("s3_second", 32'(grant_log[1]), 32'd2);
            check("s3_third", 32'(grant_log[2]), 32'd3);
            check("s3_gap", 32'((grant_cyc[1] - grant_cyc[0] >= 2) && (grant_cyc[2] - grant_cyc[1] >= 2)), 32'd1);
        end

        // Zero-length request completes immediately with no grant
        do_reset();
        apply_stimulus(4'b0100, 8'b0, 0, 0, 0, 0, '1);
        step();
        check("s4_done", 32'({done, grant_valid, response}), 32'({4'b0100, 1'b0, 4'b0}));
        req = 4'b0;
        step();
        check("s4_done_clear", 32'(done), 32'd0);

        // Two bursts ending on the same edge are released back to back
        do_reset();
        apply_stimulus(4'b1001, 8'b1000_0001, 4, 0, 0, 2, '1);
        repeat (3) step();
        req = 4'b0;
        repeat (6) step();
        check("s5_releases", 32'(release_log.size()), 32'd2);
        if (release_log.size() == 2) begin
            check("s5_rel_first", 32'(release_log[0]), 32'd0);
            check("s5_rel_second", 32'(release_log[1]), 32'd3);
            check("s5_rel_cycles", 32'(release_cyc[0]), 32'd5);
            check("s5_rel_adjacent", 32'(release_cyc[1]), 32'd6);
        end

        // Reset in the middle of a long burst aborts it silently
        do_reset();
        apply_stimulus(4'b0001, 8'b0000_0001, 10, 0, 0, 0, '1);
        step();
        req = 4'b0;
        repeat (3) step();
        check("s6_busy", 32'(response[0]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("s6_async_clear", 32'({grant_valid, release_valid, response, active, done}), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        n = release_log.size();
        repeat (12) step();
        check("s6_no_release", 32'(release_log.size()), 32'(n));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            req_dest = 8'($urandom());
            for (int k = 0; k < 4; k++) begin
                req_len[LEN_W*k +: LEN_W] = ($urandom_range(0, 7) == 0) ? '0 : LEN_W'($urandom_range(1, 6));
            end
            path_free = ($urandom_range(0, 1) == 0) ? 28'($urandom() | $urandom())
                                                   : 28'($urandom() & $urandom());
            step();
        end
        req = 4'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
